// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (port 0) has default priority, loader (port 1) gets bounded wait and short locked bursts.
// Build option: define DMEM_ARB_STATS_EN to add the beats0/beats1/max_wait1 statistics outputs.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]   beats0,
    output logic [31:0]   beats1,
    output logic [3:0]    max_wait1,
`endif
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    logic       owner_lock_reg, owner_lock_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic [7:0] lock_cnt_reg, lock_cnt_next;
    logic [7:0] lock_inc;
    logic [1:0] rd_own_reg, rd_own_next;
    logic [1:0] gnt;
    logic [1:0] rvalid_vec;

    // Grant decision. A forced lock release always follows a port-1 beat, which
    // clears wait_cnt, so the core naturally wins the cycle after the release.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (owner_lock_reg && req1) begin
                gnt = 2'b10;
            end else if (req0 && req1) begin
                gnt = (wait_cnt_reg == WAIT_LIMIT) ? 2'b10 : 2'b01;
            end else if (req0) begin
                gnt = 2'b01;
            end else if (req1) begin
                gnt = 2'b10;
            end
        end
    end

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    always_comb begin
        mem_en    = gnt[0] | gnt[1];
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[1]) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end else if (gnt[0]) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end
    end

    assign lock_inc = lock_cnt_reg + 8'd1;

    always_comb begin
        wait_cnt_next   = wait_cnt_reg;
        owner_lock_next = owner_lock_reg;
        lock_cnt_next   = lock_cnt_reg;
        rd_own_next     = gnt & {~we1, ~we0};

        if (!req1 || gnt[1]) begin
            wait_cnt_next = 4'd0;
        end else if (wait_cnt_reg != WAIT_LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end

        // A locked beat that would reach the limit falls through to the release branch.
        if (gnt[1] && lock1 && (lock_inc != LOCK_LIMIT)) begin
            owner_lock_next = 1'b1;
            lock_cnt_next   = lock_inc;
        end else if (gnt[1] || !req1) begin
            owner_lock_next = 1'b0;
            lock_cnt_next   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_lock_reg <= 1'b0;
            wait_cnt_reg   <= 4'd0;
            lock_cnt_reg   <= 8'd0;
            rd_own_reg     <= 2'b00;
        end else begin
            owner_lock_reg <= owner_lock_next;
            wait_cnt_reg   <= wait_cnt_next;
            lock_cnt_reg   <= lock_cnt_next;
            rd_own_reg     <= rd_own_next;
        end
    end

    // A response still in flight when reset arrives is dropped.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
            assign rvalid_vec[gi] = rd_own_reg[gi] & rst_n;
        end
    endgenerate

    assign rvalid0 = rvalid_vec[0];
    assign rvalid1 = rvalid_vec[1];
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] beats0_reg, beats1_reg;
    logic [3:0]  max_wait1_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beats0_reg    <= 32'd0;
            beats1_reg    <= 32'd0;
            max_wait1_reg <= 4'd0;
        end else begin
            if (gnt[0]) beats0_reg <= beats0_reg + 32'd1;
            if (gnt[1]) beats1_reg <= beats1_reg + 32'd1;
            if (wait_cnt_reg > max_wait1_reg) max_wait1_reg <= wait_cnt_reg;
        end
    end

    assign beats0    = beats0_reg;
    assign beats1    = beats1_reg;
    assign max_wait1 = max_wait1_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter with a small registered-read memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, req0, we0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] beats0, beats1;
    logic [3:0]  max_wait1;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .MAX_LOCK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef DMEM_ARB_STATS_EN
        .beats0(beats0), .beats1(beats1), .max_wait1(max_wait1),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
    end

    typedef struct {
        logic        rst_n, req0, we0, req1, we1, lock1;
        logic [31:0] addr0, wdata0, addr1, wdata1;
        logic        gnt0, gnt1, rv0, rv1, en, we;
        logic [31:0] maddr, mwdata, rdata;
    } vec_t;

    // Expected memory command is the granted port's fields, zero when idle.
    function automatic vec_t mk(input logic r, input logic q0, input logic w0,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic q1, input logic w1, input logic [31:0] a1,
                                input logic [31:0] d1, input logic l1,
                                input logic g0, input logic g1, input logic v0,
                                input logic v1, input logic [31:0] rd);
        vec_t v;
        v.rst_n = r; v.req0 = q0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
        v.req1 = q1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1; v.lock1 = l1;
        v.gnt0 = g0; v.gnt1 = g1; v.rv0 = v0; v.rv1 = v1; v.rdata = rd;
        v.en = g0 | g1;
        v.we = g1 ? w1 : (g0 ? w0 : 1'b0);
        v.maddr = g1 ? a1 : (g0 ? a0 : 32'h0);
        v.mwdata = g1 ? d1 : (g0 ? d0 : 32'h0);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [69:0] act, exp;
        logic        ok;
        @(negedge clk);
        rst_n = v.rst_n; req0 = v.req0; we0 = v.we0; addr0 = v.addr0; wdata0 = v.wdata0;
        req1 = v.req1; we1 = v.we1; addr1 = v.addr1; wdata1 = v.wdata1; lock1 = v.lock1;
        #2;
        act = {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata};
        exp = {v.gnt0, v.gnt1, v.rv0, v.rv1, v.en, v.we, v.maddr, v.mwdata};
        ok = (act === exp) &&
             (!(v.rv0 || v.rv1) || ((rdata0 === v.rdata) && (rdata1 === v.rdata)));
        n_vec++;
        $display("%-10s g=%b%b rv=%b%b en=%b we=%b addr=%h wd=%h rd=%h",
                 name, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata, rdata0);
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got g=%b%b rv=%b%b en=%b we=%b addr=%h wd=%h rd=%h/%h, want g=%b%b rv=%b%b en=%b we=%b addr=%h wd=%h rd=%h",
                     name, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata,
                     rdata0, rdata1, v.gnt0, v.gnt1, v.rv0, v.rv1, v.en, v.we, v.maddr, v.mwdata, v.rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [5:0]  con_g1;
        logic [18:0] bst_g1;
        logic        pg0, pg1, g1;
        logic [31:0] rd;
        int          k;

        rst_n = 1'b0; req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
        addr0 = '0; wdata0 = '0; addr1 = '0; wdata1 = '0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hAAAA0001;
        mem[8'h20] = 32'hBBBB0002;

        //            rst q0 w0 addr0  wdata0 q1 w1 addr1  wdata1 l1  g0 g1 v0 v1 rdata
        tbl.push_back(mk(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0, 0, 0, 0, 0, 32'h0));         // reset forces grants off
        tbl.push_back(mk(0, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0,  32'h0, 0, 1, 0, 0, 0, 32'h0));         // solo read port 0
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 1, 0, 32'hAAAA0001));
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 1, 0, 32'h20, 32'h0, 0, 0, 1, 0, 0, 32'h0));         // solo read port 1
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 1, 32'hBBBB0002));
        tbl.push_back(mk(1, 1, 1, 32'h40, 32'h5, 0, 0, 32'h0,  32'h0, 0, 1, 0, 0, 0, 32'h0));         // store 5 to 0x40
        tbl.push_back(mk(1, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0,  32'h0, 0, 1, 0, 0, 0, 32'h0));         // load 0x40, no rvalid for store
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 1, 0, 32'h5));
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 1, 1, 32'h30, 32'h11, 1, 0, 1, 0, 0, 32'h0));        // lock burst 1,1,0
        tbl.push_back(mk(1, 1, 0, 32'h10, 32'h0, 1, 1, 32'h34, 32'h12, 1, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h10, 32'h0, 1, 1, 32'h38, 32'h13, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h10, 32'h0, 1, 1, 32'h3C, 32'h14, 0, 1, 0, 0, 0, 32'h0));        // lock gone: core wins
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 1, 1, 32'h3C, 32'h14, 0, 0, 1, 1, 0, 32'hAAAA0001));
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h20, 32'h0, 0, 0, 32'h0,  32'h0, 0, 1, 0, 0, 0, 32'h0));         // read then reset
        tbl.push_back(mk(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 1, 0, 32'h20, 32'h0, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 1, 32'hBBBB0002));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Both ports read continuously: port 1 wins only once wait reaches 4.
        con_g1 = 6'b010000;
        pg0 = 1'b0; pg1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            g1 = con_g1[c];
            rd = pg0 ? 32'hAAAA0001 : (pg1 ? 32'hBBBB0002 : 32'h0);
            v = mk(1, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0, !g1, g1, pg0, pg1, rd);
            apply(v, $sformatf("contend%0d", c));
            pg0 = !g1; pg1 = g1;
        end
        v = mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, pg0, pg1,
               pg0 ? 32'hAAAA0001 : 32'hBBBB0002);
        apply(v, "contend_end");

        // Ten locked port-1 writes against a busy core: 8-beat cap, then the wait rule again.
        bst_g1 = 19'b0110000111111110000;
        k = 0; pg0 = 1'b0;
        for (int c = 0; c < 19; c++) begin
            g1 = bst_g1[c];
            v = mk(1, c < 18, 0, 32'h10, 32'h0, k < 10, 1, 32'h80 + 32'(4 * k), 32'(k), k < 10,
                   (c < 18) && !g1, g1, pg0, 0, 32'hAAAA0001);
            apply(v, $sformatf("burst%0d", c));
            pg0 = (c < 18) && !g1;
            if (g1) k++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
